// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and defaults for the unified-memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  localparam int C_DEFAULT_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
// mem_arb_timer : per-transaction wait counter with clear, enable and expiry
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin sharing of one single-port memory between the
//               instruction-fetch and data ports, with a timeout watchdog
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ack,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  port_t            last_q, last_d;     // also identifies the port being served
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic             d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic             busy_q, busy_d;

  logic             w_tmr_clr, w_tmr_en, w_expire;
  port_t            w_pick;
  logic [WIDTH-1:0] w_rdata;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (w_tmr_clr),
    .en_i     (w_tmr_en),
    .expire_o (w_expire)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_rdata     = '0;
    // On a tie the port that was not served last wins.
    w_pick = (i_req && d_req) ? ((last_q == INSTR) ? DATA : INSTR)
                              : (d_req ? DATA : INSTR);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_d      = w_pick;
          mem_req_d   = 1'b1;
          mem_we_d    = (w_pick == DATA) ? d_we    : 1'b0;
          mem_addr_d  = (w_pick == DATA) ? d_addr  : i_addr;
          mem_wdata_d = (w_pick == DATA) ? d_wdata : '0;
          w_tmr_clr   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        w_tmr_en = 1'b1;
        // mem_ack takes priority over a simultaneous expiry.
        if (mem_ack || w_expire) begin
          w_rdata   = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (last_q == DATA) begin
            d_ack_d   = 1'b1;
            d_err_d   = !mem_ack;
            d_rdata_d = w_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = !mem_ack;
            i_rdata_d = w_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= INSTR;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : randomized self-checking bench with a transaction-level
//                  model of the arbiter and a sparse memory model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;
  localparam int BOUND   = 2 * TIMEOUT + 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [WIDTH-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic             i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;
  logic [WIDTH-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model state; ports are 0 = instruction, 1 = data.
  int          checks = 0, failures = 0;
  int          last_port = 0;
  bit          in_txn = 0, was_resp = 0;
  int          t_port = 0, t_cnt = 0, t_lat = 0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic        t_we = 1'b0;
  logic [31:0] exp_i_rd = '0, exp_d_rd = '0;
  int          force_lat = -1;
  bit          rand_en = 0, hold_en = 0;
  int          n_acks = 0, i_wait = 0, d_wait = 0, max_wait = 0;
  logic [31:0] mem_model [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6)       return r;
    else if (r < 8)  return TIMEOUT - 1;
    else if (r == 8) return TIMEOUT - 2;
    else             return NEVER;
  endfunction

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = 32'($urandom_range(0, 15)) << 2;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = ($urandom_range(0, 2) == 0);
    d_addr  = 32'($urandom_range(0, 15)) << 2;
    d_wdata = $urandom();
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_ack", {i_ack, d_ack}, 0);
    check_eq("rst_err", {i_err, d_err}, 0);
    check_eq("rst_i_rdata", i_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    in_txn = 0; was_resp = 0; last_port = 0;
    exp_i_rd = '0; exp_d_rd = '0; i_wait = 0; d_wait = 0;
  endtask

  // One cycle: observe at the falling edge, check, then drive the next inputs.
  task automatic step();
    logic [1:0] exp_ack, exp_err;
    bit         resp_now, timed_out;
    int         exp_len, exp_port;
    logic [31:0] rd;
    @(negedge clk);
    exp_ack = 2'b00; exp_err = 2'b00; resp_now = 0;
    mem_ack = 1'b0;
    mem_rdata = $urandom();
    if (was_resp) check_eq("turnaround_mem_req", mem_req, 0);

    if (in_txn && !mem_req) begin
      resp_now  = 1;
      timed_out = (t_lat >= TIMEOUT);
      exp_len   = timed_out ? TIMEOUT : t_lat + 1;
      check_eq("req_len", t_cnt, exp_len);
      rd = (timed_out || t_we) ? 32'd0 : mem_lookup(t_addr);
      if (t_port == 1) begin exp_ack = 2'b01; exp_d_rd = rd; end
      else             begin exp_ack = 2'b10; exp_i_rd = rd; end
      exp_err = timed_out ? exp_ack : 2'b00;
      if (!timed_out && t_we) mem_model[t_addr] = t_wdata;
      in_txn = 0;
      n_acks++;
    end else if (in_txn && mem_req) begin
      t_cnt++;
      if (t_cnt > TIMEOUT) begin
        check_eq("req_len_over", t_cnt, TIMEOUT);
        in_txn = 0;
      end
    end else if (!in_txn && mem_req) begin
      if (!i_req && !d_req) begin
        check_eq("grant_without_req", 1, 0);
      end else begin
        exp_port  = (i_req && d_req) ? (last_port == 0 ? 1 : 0) : (d_req ? 1 : 0);
        last_port = exp_port;
        t_port    = exp_port;
        t_addr    = (exp_port == 1) ? d_addr  : i_addr;
        t_we      = (exp_port == 1) ? d_we    : 1'b0;
        t_wdata   = (exp_port == 1) ? d_wdata : 32'd0;
        check_eq("mem_addr", mem_addr, t_addr);
        check_eq("mem_we", mem_we, t_we);
        if (t_we) check_eq("mem_wdata", mem_wdata, t_wdata);
        t_lat  = (force_lat >= 0) ? force_lat : pick_lat();
        t_cnt  = 1;
        in_txn = 1;
      end
    end

    if (in_txn && mem_req) begin
      if (t_cnt - 1 == t_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = t_we ? $urandom() : mem_lookup(mem_addr);
      end
    end else begin
      mem_ack = ($urandom_range(0, 7) == 0);
    end

    check_eq("ack", {i_ack, d_ack}, exp_ack);
    check_eq("err", {i_err, d_err}, exp_err);
    check_eq("i_rdata", i_rdata, exp_i_rd);
    check_eq("d_rdata", d_rdata, exp_d_rd);
    check_eq("busy", busy, resp_now || (in_txn && mem_req));
    was_resp = resp_now;

    if (i_req && !(resp_now && t_port == 0)) i_wait++; else i_wait = 0;
    if (d_req && !(resp_now && t_port == 1)) d_wait++; else d_wait = 0;
    if (i_wait > max_wait) max_wait = i_wait;
    if (d_wait > max_wait) max_wait = d_wait;

    if (resp_now && t_port == 0) begin
      if (!hold_en) begin
        if (rand_en && $urandom_range(0, 1) == 1) new_i(); else i_req = 1'b0;
      end
    end else if (!i_req && rand_en && $urandom_range(0, 2) == 0) new_i();
    if (resp_now && t_port == 1) begin
      if (!hold_en) begin
        if (rand_en && $urandom_range(0, 1) == 1) new_d(); else d_req = 1'b0;
      end
    end else if (!d_req && rand_en && $urandom_range(0, 2) == 0) new_d();
  endtask

  task automatic run_txns(input int n);
    int target, guard;
    target = n_acks + n;
    guard  = 0;
    while (n_acks < target && guard < n * (TIMEOUT + 8)) begin
      step();
      guard++;
    end
    check_eq("txn_count", n_acks, target);
  endtask

  initial begin
    do_reset();

    // Single fetch, memory answers in the third BUSY cycle.
    mem_model[32'h40] = 32'h8C01_0004;
    force_lat = 2; i_addr = 32'h40; i_req = 1'b1;
    run_txns(1);

    // Both ports held: expect D, I, D, I, then drain.
    force_lat = 0; hold_en = 1;
    i_addr = 32'h44; d_addr = 32'h48; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    run_txns(3);
    hold_en = 0;
    run_txns(2);

    // Write, then fetch it back through the unified memory.
    force_lat = 1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    run_txns(1);
    force_lat = 0; i_addr = 32'h100; i_req = 1'b1;
    run_txns(1);

    // Watchdog expiry with no mem_ack.
    force_lat = NEVER; d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    run_txns(1);

    // mem_ack in the last allowed cycle wins over the timeout.
    mem_model[32'h84] = 32'h1234_5678;
    force_lat = TIMEOUT - 1; d_addr = 32'h84; d_req = 1'b1;
    run_txns(1);

    // Reset while BUSY aborts silently; the first tie afterwards goes to data.
    force_lat = NEVER; d_addr = 32'h88; d_req = 1'b1;
    for (int k = 0; k < 10 && !(in_txn && t_cnt >= 5); k++) step();
    check_eq("mid_busy_reached", in_txn, 1);
    do_reset();
    force_lat = 0; i_addr = 32'h8; d_addr = 32'hC; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    run_txns(2);

    // Randomized traffic, then let both requesters go quiet.
    force_lat = -1; rand_en = 1;
    repeat (1500) step();
    rand_en = 0;
    repeat (3 * (TIMEOUT + 4)) step();
    check_eq("max_wait_within_bound", (max_wait <= BOUND), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the cpu instruction-fetch port and the cpu data port.
- Two-way round-robin grant, one outstanding memory transaction at a time.
- Per-transaction timeout watchdog.
- Sits between the cpu and the memory model; the top level uses it to replace split instruction/data memories.

Parameters:
- WIDTH, 32, address and data width.
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before the transaction is aborted (must be >= 1).
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  instruction fetch request; held with i_addr stable until i_ack.
- i_addr  input  WIDTH  fetch address (pc).
- i_ack  output  1  one-cycle completion pulse for fetch.
- i_rdata  output  WIDTH  fetched instruction; valid while i_ack=1.
- i_err  output  1  pulses with i_ack when the fetch timed out.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  WIDTH  data address (aluOut).
- d_wdata  input  WIDTH  store data (writeData).
- d_ack  output  1  one-cycle completion pulse for data.
- d_rdata  output  WIDTH  load data; valid while d_ack=1; 0 for writes.
- d_err  output  1  pulses with d_ack on timeout.
- mem_req  output  1  memory request, held until mem_ack or timeout.
- mem_we  output  1  memory write enable.
- mem_addr  output  WIDTH  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory read data; sampled when mem_ack=1.
- mem_ack  input  1  memory completion, one cycle.
- busy  output  1  high in BUSY and RESP.

Behaviour:
- All outputs are registered.
- On reset:
  - state=IDLE; last_grant=INSTR.
  - Counter=0.
  - All ack, err, mem_req and mem_we outputs = 0.
  - All data and address outputs = 0.
- Reset mid-transaction aborts it silently: no ack is issued, and mem_req drops on the next edge.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port not in last_grant. After reset, the first tie therefore goes to DATA.
  - On grant: latch addr, we (0 for INSTR) and wdata into the mem_* registers, set mem_req=1, update last_grant, clear the counter, go to BUSY.
  - Latency: a request sampled at edge N gives mem_req=1 after edge N.
- BUSY:
  - mem_req stays high; the counter increments each cycle.
  - If mem_ack=1: capture mem_rdata into the granted port's rdata (0 for writes), set mem_req=0, assert the granted port's ack, go to RESP.
  - Else if counter == TIMEOUT-1: set mem_req=0, assert the granted port's ack and err, set its rdata=0, go to RESP.
  - If mem_ack and timeout expiry coincide, mem_ack wins and err=0.
- RESP:
  - The ack (and err, if set) is high for exactly this one cycle.
  - Requests are not evaluated in RESP. Requesters may change or drop req from the edge at which they see ack.
  - Next state: IDLE. Minimum turnaround from one grant to the next is 3 cycles when mem_ack is immediate.
- mem_ack seen in IDLE or RESP is ignored.
- rdata outputs hold their last value outside their ack cycle.
- i_ack and d_ack are never high in the same cycle.

Decomposition:
- Shared package mem_arb_pkg contains:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - port_t enum {INSTR, DATA}
  - a default TIMEOUT constant
- One natural sub-module, mem_arb_timer:
  - Loadable wait counter with clear, enable and an expire flag (counter == TIMEOUT-1).
  - Instantiated once.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=0x40, memory acks 2 cycles after mem_req with 0x8C010004 -> mem_addr=0x40, mem_we=0, i_ack pulses 1 cycle with i_rdata=0x8C010004, i_err=0.
- Simultaneous first requests: i_req=d_req=1 after reset -> DATA granted first (mem_addr=d_addr), INSTR granted next. With both held for 4 transactions, grants alternate D,I,D,I.
- Write: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_ack with d_rdata=0, i_ack stays 0.
- Timeout: TIMEOUT=16, mem_ack never asserted -> mem_req high exactly 16 cycles, then d_ack=d_err=1 for one cycle, d_rdata=0, then IDLE.
- Ack at expiry: mem_ack asserted in the 16th BUSY cycle with 0x12345678 -> ack with err=0, rdata=0x12345678.
- Reset mid-BUSY: assert reset during BUSY -> next cycle mem_req=0, busy=0, no ack. After reset, a tie grants DATA first.
